param_fir_filter: RTL and testbench
===================================

PARAM_FIR_FILTER -- requirements
Module: param_fir_filter

Interface
REQ-001 Parameter DATA_W, default 16: width of samples, coefficients and fir_out.
REQ-002 Parameter NUM_TAPS, default 4: number of filter taps, minimum 2.
REQ-003 Parameter SAMPLE_CNT_MAX, default 1000: processed-sample count that raises one_k_samples.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 sample_data  input  DATA_W  unsigned sample, captured when data_ready is accepted.
REQ-007 fir_coefficient  input  DATA_W  unsigned Q0.DATA_W coefficient, captured when load_coeff is accepted.
REQ-008 load_coeff  input  1  synchronous one-cycle coefficient strobe.
REQ-009 data_ready  input  1  synchronous one-cycle sample strobe.
REQ-010 modwait  output  1  high while the block is busy (any state other than IDLE).
REQ-011 fir_out  output  DATA_W  magnitude of the last filter result.
REQ-012 err  output  1  sticky error flag.
REQ-013 one_k_samples  output  1  one-cycle pulse on reaching SAMPLE_CNT_MAX.

Function
REQ-014 FSM states: IDLE, LOAD, SHIFT, MAC, DONE; IDLE accepts strobes, every other state is busy.
REQ-015 IDLE + load_coeff -> LOAD (1 cycle): coefficient written to coef[idx], idx increments and wraps NUM_TAPS-1 -> 0, then IDLE.
REQ-016 IDLE + data_ready -> SHIFT (1 cycle): history shifts, sample_data enters tap 0 (newest), oldest sample discarded, accumulator cleared.
REQ-017 MAC: exactly NUM_TAPS cycles, cycle k adds (+1 for even k, -1 for odd k) * ((s[k]*coef[k]) >> DATA_W) into a signed accumulator of DATA_W+$clog2(NUM_TAPS)+1 bits; the accumulator never wraps internally.
REQ-018 DONE (1 cycle): fir_out <= |acc| low DATA_W bits, sample counter increments, then IDLE.
REQ-019 Latency: data_ready accepted at cycle 0 -> fir_out valid and modwait low at cycle NUM_TAPS+2.
REQ-020 Overflow: if |acc| > 2^DATA_W-1 in DONE, err <= 1.
REQ-021 err clears only in DONE of a sample that does not overflow.
REQ-022 data_ready asserted while modwait is high: sample ignored, err <= 1, current computation completes unaffected.
REQ-023 load_coeff asserted while modwait is high: ignored, no err.
REQ-024 load_coeff and data_ready together in IDLE: load_coeff wins, data_ready dropped, no err.
REQ-025 Sample counter reaches SAMPLE_CNT_MAX in DONE: one_k_samples high for exactly the following cycle, counter wraps to 0.

Reset
REQ-026 n_rst low: state IDLE; modwait, err and one_k_samples 0; fir_out 0; coefficients, history, idx, accumulator and counter 0, including mid-MAC.

Configuration
REQ-027 FIR_SATURATE_EN defined: overflow clamps fir_out to all ones and does not set err. Undefined: REQ-018/REQ-020 truncation and err apply.

Structure
REQ-028 Package fir_pkg holds the state enum and the default DATA_W, NUM_TAPS and SAMPLE_CNT_MAX constants.
REQ-029 Sample counter is sub-module flex_counter (parametrised rollover, clear, count_enable, rollover flag).

Verification
REQ-030 Reset mid-MAC -> next cycle modwait=0, fir_out=0, err=0, all coefficients read back 0.
REQ-031 Load four coefficients of 0x8000, then samples 100, 200, 300, 400 -> final fir_out=100 exactly 6 cycles after the last data_ready, err=0.
REQ-032 Coefficients 0xFFFF, 0, 0xFFFF, 0 with four samples of 0xFFFF -> fir_out=0xFFFC, err=1; with FIR_SATURATE_EN: fir_out=0xFFFF, err=0.
REQ-033 data_ready pulsed 2 cycles after a previous accepted data_ready -> err=1, in-flight result correct; next clean sample -> err=0.
REQ-034 load_coeff and data_ready in the same IDLE cycle -> coefficient stored, modwait high 1 cycle only, history unchanged.
REQ-035 SAMPLE_CNT_MAX=3: three samples processed -> single one_k_samples pulse one cycle after the third DONE; the sixth sample pulses again.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the parameterised FIR filter.
package fir_pkg;
  localparam int FIR_DATA_W         = 16;
  localparam int FIR_NUM_TAPS       = 4;
  localparam int FIR_SAMPLE_CNT_MAX = 1000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    MAC,
    DONE
  } fir_state_e;
endpackage

// File: rtl/flex_counter.sv
// Counter with programmable rollover value; the flag pulses for one cycle
// right after the increment that reaches the rollover value.
module flex_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic             rollover_flag
);
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             flag_q, flag_d;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_inc == rollover_val) begin
        count_d = '0;
        flag_d  = 1'b1;
      end else begin
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag = flag_q;
endmodule

// File: rtl/param_fir_filter.sv
// Sequential alternating-sign FIR: one multiply per cycle over NUM_TAPS taps.
// Define FIR_SATURATE_EN to clamp overflowing results instead of flagging err.
module param_fir_filter
  import fir_pkg::*;
#(
  parameter int DATA_W         = FIR_DATA_W,
  parameter int NUM_TAPS       = FIR_NUM_TAPS,
  parameter int SAMPLE_CNT_MAX = FIR_SAMPLE_CNT_MAX
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] fir_coefficient,
  input  logic              load_coeff,
  input  logic              data_ready,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err,
  output logic              one_k_samples
);
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int ACC_W = DATA_W + $clog2(NUM_TAPS) + 1;
  localparam int CNT_W = $clog2(SAMPLE_CNT_MAX + 1);

  fir_state_e                           state_q;
  logic [NUM_TAPS-1:0][DATA_W-1:0]      coef_q, hist_q;
  logic [DATA_W-1:0]                    din_q, fir_out_q;
  logic [IDX_W-1:0]                     idx_q, tap_q;
  logic signed [ACC_W-1:0]              acc_q, term;
  logic [ACC_W-1:0]                     acc_abs;
  logic [2*DATA_W-1:0]                  prod;
  logic                                 err_q, modwait_q, ovf;

  // Q0.DATA_W coefficient: keep only the integer part of the product.
  assign prod    = hist_q[tap_q] * coef_q[tap_q];
  assign term    = ACC_W'(prod >> DATA_W);
  assign acc_abs = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
  assign ovf     = |(acc_abs >> DATA_W);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      coef_q    <= '0;
      hist_q    <= '0;
      din_q     <= '0;
      idx_q     <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      fir_out_q <= '0;
      err_q     <= 1'b0;
      modwait_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_coeff) begin
            din_q     <= fir_coefficient;
            state_q   <= LOAD;
            modwait_q <= 1'b1;
          end else if (data_ready) begin
            din_q     <= sample_data;
            state_q   <= SHIFT;
            modwait_q <= 1'b1;
          end
        end
        LOAD: begin
          coef_q[idx_q] <= din_q;
          idx_q         <= (idx_q == IDX_W'(NUM_TAPS - 1)) ? '0 : idx_q + 1'b1;
          state_q       <= IDLE;
          modwait_q     <= 1'b0;
        end
        SHIFT: begin
          hist_q  <= {hist_q[NUM_TAPS-2:0], din_q};
          acc_q   <= '0;
          tap_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= tap_q[0] ? acc_q - term : acc_q + term;
          tap_q <= tap_q + 1'b1;
          if (tap_q == IDX_W'(NUM_TAPS - 1)) state_q <= DONE;
        end
        DONE: begin
`ifdef FIR_SATURATE_EN
          fir_out_q <= ovf ? '1 : acc_abs[DATA_W-1:0];
          err_q     <= 1'b0;
`else
          fir_out_q <= acc_abs[DATA_W-1:0];
          err_q     <= ovf;
`endif
          state_q   <= IDLE;
          modwait_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          modwait_q <= 1'b0;
        end
      endcase
      // A sample offered while busy is dropped and flagged; this wins over DONE.
      if (state_q != IDLE && data_ready) err_q <= 1'b1;
    end
  end

  flex_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (1'b0),
    .count_enable (state_q == DONE),
    .rollover_val (CNT_W'(SAMPLE_CNT_MAX)),
    .rollover_flag(one_k_samples)
  );

  assign modwait = modwait_q;
  assign fir_out = fir_out_q;
  assign err     = err_q;
endmodule

// File: tb/tb_param_fir_filter.sv
// Scoreboard bench for param_fir_filter: drivers push expected results, a
// negedge monitor pops them whenever modwait falls.
module tb_param_fir_filter;
  localparam int W = 16, N = 4, CMAX = 3;

  logic         clk = 1'b0, n_rst;
  logic [W-1:0] sample_data, fir_coefficient;
  logic         load_coeff, data_ready;
  logic         modwait, err, one_k;
  logic [W-1:0] fir_out;

  always #5 clk = ~clk;

  param_fir_filter #(.DATA_W(W), .NUM_TAPS(N), .SAMPLE_CNT_MAX(CMAX)) dut (
    .clk(clk), .n_rst(n_rst), .sample_data(sample_data),
    .fir_coefficient(fir_coefficient), .load_coeff(load_coeff),
    .data_ready(data_ready), .modwait(modwait), .fir_out(fir_out),
    .err(err), .one_k_samples(one_k)
  );

  typedef struct {
    bit           is_load;
    logic [W-1:0] fout;
    bit           e;
    bit           onek;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, fails = 0, cyc = 0;
  bit   prev_mw = 1'b0;

  longint       mcoef[N], mhist[N];
  int           midx, mcnt;
  bit           merr;
  logic [W-1:0] mfout;

  always @(posedge clk) cyc++;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin mcoef[k] = 0; mhist[k] = 0; end
    midx = 0; mcnt = 0; merr = 0; mfout = '0;
  endfunction

  // Filter result straight from the definition: signed alternating sum of
  // floor(sample*coef / 2^W), then magnitude and range check.
  function automatic bit model_sample(input logic [W-1:0] s);
    longint acc = 0, a;
    bit ovf, pulse = 0;
    for (int k = N - 1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = s;
    for (int k = 0; k < N; k++) begin
      if (k % 2 == 0) acc += (mhist[k] * mcoef[k]) / 65536;
      else            acc -= (mhist[k] * mcoef[k]) / 65536;
    end
    a   = (acc < 0) ? -acc : acc;
    ovf = a > 65535;
`ifdef FIR_SATURATE_EN
    mfout = ovf ? 16'hFFFF : a[W-1:0];
    merr  = 0;
`else
    mfout = a[W-1:0];
    merr  = ovf;
`endif
    mcnt++;
    if (mcnt == CMAX) begin mcnt = 0; pulse = 1; end
    return pulse;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (modwait && n < 100) begin @(negedge clk); n++; end
    if (modwait) check("idle_timeout", modwait, 0);
  endtask

  task automatic do_load(input logic [W-1:0] c, input bit with_sample = 0,
                         input logic [W-1:0] s = '0);
    exp_t e;
    wait_idle();
    fir_coefficient = c; load_coeff = 1; data_ready = with_sample; sample_data = s;
    mcoef[midx] = c; midx = (midx + 1) % N;
    e.is_load = 1; e.fout = mfout; e.e = merr; e.onek = 0; e.due = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    load_coeff = 0; data_ready = 0;
  endtask

  task automatic do_sample(input logic [W-1:0] s, input bit busy_pulse = 0);
    exp_t e;
    wait_idle();
    sample_data = s; data_ready = 1;
    e.onek = model_sample(s);
    e.is_load = 0; e.fout = mfout; e.e = merr; e.due = cyc + N + 3;
    sb.push_back(e);
    @(negedge clk);
    data_ready = 0;
    if (busy_pulse) begin
      @(negedge clk);
      sample_data = ~s; data_ready = 1;
      @(negedge clk);
      data_ready = 0;
      check("busy_err_set", err, 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      prev_mw = 0;
    end else begin
      if (prev_mw && !modwait) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check(e.is_load ? "load_fir_out" : "fir_out", fir_out, e.fout);
          check(e.is_load ? "load_err" : "err", err, e.e);
          check("one_k_samples", one_k, e.onek);
          check(e.is_load ? "load_latency" : "sample_latency", cyc, e.due);
        end
      end else begin
        check("one_k_idle", one_k, 0);
      end
      prev_mw = modwait;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    n_rst = 0; load_coeff = 0; data_ready = 0; sample_data = '0; fir_coefficient = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_modwait", modwait, 0);
    check("rst_fir_out", fir_out, 0);
    check("rst_err", err, 0);
    check("rst_one_k", one_k, 0);
    n_rst = 1;

    // Half-scale coefficients over a ramp: expected magnitude 100.
    repeat (N) do_load(16'h8000);
    do_sample(100); do_sample(200); do_sample(300); do_sample(400);
    wait_idle();
    check("ramp_result", fir_out, 100);
    check("ramp_err", err, 0);

    // Full-scale overflow case.
    do_load(16'hFFFF); do_load(16'h0000); do_load(16'hFFFF); do_load(16'h0000);
    repeat (N) do_sample(16'hFFFF);
    wait_idle();
`ifdef FIR_SATURATE_EN
    check("ovf_result", fir_out, 16'hFFFF);
    check("ovf_err", err, 0);
`else
    check("ovf_result", fir_out, 16'hFFFC);
    check("ovf_err", err, 1);
`endif

    // Sample offered while busy, then a clean sample.
    repeat (N) do_load(16'h1000);
    do_sample(16'h1234, 1);
    do_sample(16'h0800);
    wait_idle();
    check("err_cleared", err, 0);

    // Simultaneous strobes: coefficient wins, history must be untouched.
    do_load(16'h4000, 1, 16'hBEEF);
    repeat (3) do_sample(16'($urandom_range(0, 16'hFFFF)));

    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 9) < 3) do_load(v);
      else                          do_sample(v);
    end

    // Reset in the middle of MAC, with err driven high beforehand.
    do_load(16'hFFFF); do_load(16'h0000); do_load(16'hFFFF); do_load(16'h0000);
    repeat (N) do_sample(16'hFFFF);
    wait_idle();
    sample_data = 16'h7777; data_ready = 1;
    @(negedge clk);
    data_ready = 0;
    repeat (2) @(negedge clk);
    #2 n_rst = 0;
    sb.delete();
    model_reset();
    @(negedge clk);
    #2 n_rst = 1;
    @(negedge clk);
    check("midrst_modwait", modwait, 0);
    check("midrst_fir_out", fir_out, 0);
    check("midrst_err", err, 0);
    for (int i = 0; i < N + 1; i++) do_sample(16'($urandom_range(1, 16'hFFFF)));
    do_load(16'h8000);
    do_sample(16'h0400);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
